// File: rtl/daq_optical_pkg.sv
// Shared types and defaults for the DAQ optical TX path: sequencer state
// encoding, timeout defaults and TX rate encoding.
package daq_optical_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK    = 3'd0,
        TXRST        = 3'd1,
        WAIT_RSTDONE = 3'd2,
        APPLY        = 3'd3,
        WAIT_TEST    = 3'd4,
        READY        = 3'd5,
        FAIL         = 3'd6
    } tx_state_t;

    localparam int DEF_RST_HOLD_CYCLES   = 32;
    localparam int DEF_RESETDONE_TIMEOUT = 4096;
    localparam int DEF_TESTDONE_TIMEOUT  = 8192;
    localparam int DEF_MAX_RETRIES       = 7;

    localparam logic RATE_FULL = 1'b0;
    localparam logic RATE_DIV  = 1'b1;

endpackage

// File: rtl/sync2_ff.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module sync2_ff (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    logic meta;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta <= 1'b0;
            Q    <= 1'b0;
        end else begin
            meta <= D;
            Q    <= meta;
        end
    end

endmodule

// File: rtl/gtx_tx_init_seq.sv
// GTX TX power-up / rate-change sequencer with timeout retries.
// Optional lock-loss counter output enabled by GTX_LOCK_LOSS_CNT_EN.
//
// state        | meaning
// WAIT_LOCK    | hold resets until synchronised PLL lock
// TXRST        | TXRESET held for RST_HOLD_CYCLES
// WAIT_RSTDONE | wait for TXRESETDONE, retry on timeout
// APPLY        | load TX_RATE while INIT is still high
// WAIT_TEST    | INIT low, wait for GTXTEST_DONE rising edge
// READY        | link usable, watch for rate requests
// FAIL         | retries exhausted, left only by RST
module gtx_tx_init_seq
    import daq_optical_pkg::*;
#(
    parameter int RST_HOLD_CYCLES   = DEF_RST_HOLD_CYCLES,
    parameter int RESETDONE_TIMEOUT = DEF_RESETDONE_TIMEOUT,
    parameter int TESTDONE_TIMEOUT  = DEF_TESTDONE_TIMEOUT,
    parameter int MAX_RETRIES       = DEF_MAX_RETRIES,
    parameter int CTR_W             = 13
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PLLLKDET,
    input  logic       TXRESETDONE,
    input  logic       RATE_REQ,
    input  logic       GTXTEST_DONE,
    output logic       TXRESET,
    output logic       INIT,
    output logic       TX_RATE,
    output logic       TX_READY,
    output logic       TIMEOUT_ERR,
    output logic [3:0] RETRY_CNT
`ifdef GTX_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0] LOCK_LOSS_CNT
`endif
);

    localparam logic [CTR_W-1:0] HOLD_TC    = CTR_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CTR_W-1:0] RSTDONE_TC = CTR_W'(RESETDONE_TIMEOUT - 1);
    localparam logic [CTR_W-1:0] TEST_TC    = CTR_W'(TESTDONE_TIMEOUT - 1);
    localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRIES);

    tx_state_t        state, state_nx;
    logic [CTR_W-1:0] timer;
    logic             lock_s, rstdone_s, gtd_q, test_edge;
    logic             retry_take, counting;
    logic [3:0]       retry_inc, retry_nx;

    sync2_ff u_sync_lock (.CLK(CLK), .RST(RST), .D(PLLLKDET),    .Q(lock_s));
    sync2_ff u_sync_done (.CLK(CLK), .RST(RST), .D(TXRESETDONE), .Q(rstdone_s));

    assign test_edge = GTXTEST_DONE & ~gtd_q;
    assign retry_inc = (RETRY_CNT < RETRY_MAX) ? RETRY_CNT + 4'd1 : RETRY_CNT;
    assign counting  = (state == TXRST) || (state == WAIT_RSTDONE) || (state == WAIT_TEST);

    always_comb begin
        state_nx   = state;
        retry_nx   = RETRY_CNT;
        retry_take = 1'b0;
        case (state)
            WAIT_LOCK:    if (lock_s) state_nx = TXRST;
            TXRST:        if (timer == HOLD_TC) state_nx = WAIT_RSTDONE;
            WAIT_RSTDONE: begin
                if (rstdone_s)                 state_nx   = APPLY;
                else if (timer == RSTDONE_TC)  retry_take = 1'b1;
            end
            APPLY:        state_nx = WAIT_TEST;
            WAIT_TEST: begin
                if (test_edge)                 state_nx   = READY;
                else if (timer == TEST_TC)     retry_take = 1'b1;
            end
            READY:        if (RATE_REQ != TX_RATE) state_nx = APPLY;
            FAIL:         state_nx = FAIL;
            default:      state_nx = WAIT_LOCK;
        endcase
        if (retry_take) begin
            retry_nx = retry_inc;
            state_nx = (retry_inc == RETRY_MAX) ? FAIL : TXRST;
        end
        // Lock loss overrides everything decided above and leaves the retry count alone.
        if (!lock_s && state != WAIT_LOCK && state != FAIL) begin
            state_nx = WAIT_LOCK;
            retry_nx = RETRY_CNT;
        end
        if (state_nx == READY) retry_nx = 4'd0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= WAIT_LOCK;
            timer       <= '0;
            gtd_q       <= 1'b0;
            TXRESET     <= 1'b1;
            INIT        <= 1'b1;
            TX_RATE     <= RATE_FULL;
            TX_READY    <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            RETRY_CNT   <= 4'd0;
        end else begin
            state <= state_nx;
            gtd_q <= GTXTEST_DONE;
            if (state_nx != state) timer <= '0;
            else if (counting)     timer <= timer + CTR_W'(1);
            TXRESET  <= (state_nx == WAIT_LOCK) || (state_nx == TXRST) || (state_nx == FAIL);
            INIT     <= !((state_nx == WAIT_TEST) || (state_nx == READY));
            // Rate is captured on APPLY entry so it is stable for the whole INIT-high cycle.
            if (state_nx == APPLY && state != APPLY) TX_RATE <= RATE_REQ;
            TX_READY    <= (state_nx == READY);
            TIMEOUT_ERR <= (state_nx == FAIL);
            RETRY_CNT   <= retry_nx;
        end
    end

`ifdef GTX_LOCK_LOSS_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            LOCK_LOSS_CNT <= 8'd0;
        else if (state == READY && !lock_s && LOCK_LOSS_CNT != 8'hFF)
            LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 8'd1;
    end
`endif

endmodule

// File: tb/tb_gtx_tx_init_seq.sv
// Self-checking bench for gtx_tx_init_seq: bring-up/rate-change vector table
// plus directed timeout, FAIL, lock-loss and async-reset sequences.
module tb_gtx_tx_init_seq;

    logic       CLK = 1'b0;
    logic       RST;
    logic       PLLLKDET, TXRESETDONE, RATE_REQ, GTXTEST_DONE;
    logic       TXRESET, INIT, TX_RATE, TX_READY, TIMEOUT_ERR;
    logic [3:0] RETRY_CNT;
`ifdef GTX_LOCK_LOSS_CNT_EN
    logic [7:0] LOCK_LOSS_CNT;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    gtx_tx_init_seq dut (
        .CLK(CLK), .RST(RST), .PLLLKDET(PLLLKDET), .TXRESETDONE(TXRESETDONE),
        .RATE_REQ(RATE_REQ), .GTXTEST_DONE(GTXTEST_DONE), .TXRESET(TXRESET),
        .INIT(INIT), .TX_RATE(TX_RATE), .TX_READY(TX_READY),
        .TIMEOUT_ERR(TIMEOUT_ERR), .RETRY_CNT(RETRY_CNT)
`ifdef GTX_LOCK_LOSS_CNT_EN
        , .LOCK_LOSS_CNT(LOCK_LOSS_CNT)
`endif
    );

    // {TXRESET, INIT, TX_RATE, TX_READY, TIMEOUT_ERR, RETRY_CNT}
    function automatic logic [8:0] outs();
        return {TXRESET, INIT, TX_RATE, TX_READY, TIMEOUT_ERR, RETRY_CNT};
    endfunction

    function automatic logic sig_val(input int which);
        case (which)
            0:       return TXRESET;
            1:       return INIT;
            default: return TX_READY;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp_o);
        n_chk++;
        if (act === exp_o) n_pass++;
        else $display("FAIL %s: got %b expected %b (TXRESET,INIT,TX_RATE,TX_READY,TIMEOUT_ERR,RETRY_CNT)",
                      name, act, exp_o);
    endtask

    task automatic wait_sig(input int which, input logic val, input int budget, input string name);
        int n = 0;
        while (sig_val(which) !== val && n < budget) begin
            step(1);
            n++;
        end
        n_chk++;
        if (sig_val(which) === val) n_pass++;
        else $display("FAIL %s: signal still %b after %0d cycles, expected %b", name, sig_val(which), budget, val);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step(3);
        RST = 1'b0;
    endtask

    typedef struct {
        logic       pll, rstdone, rate, gtd;
        int         wait_n;
        logic [8:0] exp_o;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0,    9, 9'b1_1_0_0_0_0000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0,   34, 9'b1_1_0_0_0_0000};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0,    1, 9'b0_1_0_0_0_0000};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0,  100, 9'b0_1_0_0_0_0000};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0,    3, 9'b0_1_0_0_0_0000};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0,    1, 9'b0_0_0_0_0_0000};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2048, 9'b0_0_0_0_0_0000};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1,    1, 9'b0_0_0_1_0_0000};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1,    3, 9'b0_0_0_1_0_0000};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0,    5, 9'b0_0_0_1_0_0000};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0,    1, 9'b0_1_1_0_0_0000};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0,    1, 9'b0_0_1_0_0_0000};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0,   50, 9'b0_0_1_0_0_0000};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1,    1, 9'b0_0_1_1_0_0000};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0,    3, 9'b0_0_1_1_0_0000};

        PLLLKDET = 0; TXRESETDONE = 0; RATE_REQ = 0; GTXTEST_DONE = 0;
        RST = 1'b1;
        step(3);
        chk("reset_values", outs(), 9'b1_1_0_0_0_0000);
        RST = 1'b0;

        // Bring-up followed by a 0->1 rate change
        for (int i = 0; i < 15; i++) begin
            PLLLKDET     = vecs[i].pll;
            TXRESETDONE  = vecs[i].rstdone;
            RATE_REQ     = vecs[i].rate;
            GTXTEST_DONE = vecs[i].gtd;
            step(vecs[i].wait_n);
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp_o);
        end

        // Single TXRESETDONE timeout then recovery
        PLLLKDET = 1; TXRESETDONE = 0; RATE_REQ = 0; GTXTEST_DONE = 0;
        do_reset();
        wait_sig(0, 1'b0, 100, "to_txreset_fall");
        step(4095);
        chk("to_last_wait", outs(), 9'b0_1_0_0_0_0000);
        step(1);
        chk("to_retry1", outs(), 9'b1_1_0_0_0_0001);
        step(31);
        chk("to_rehold", outs(), 9'b1_1_0_0_0_0001);
        step(1);
        chk("to_rehold_end", outs(), 9'b0_1_0_0_0_0001);
        TXRESETDONE = 1;
        step(4);
        chk("to_wait_test", outs(), 9'b0_0_0_0_0_0001);
        step(10);
        GTXTEST_DONE = 1;
        step(1);
        chk("to_ready_clr", outs(), 9'b0_0_0_1_0_0000);
        GTXTEST_DONE = 0;

        // Lock loss in READY coinciding with test-done edge and rate request
        PLLLKDET = 1; TXRESETDONE = 1; RATE_REQ = 0; GTXTEST_DONE = 0;
        do_reset();
        wait_sig(1, 1'b0, 200, "ll_init_fall");
        step(5);
        GTXTEST_DONE = 1;
        step(1);
        chk("ll_ready", outs(), 9'b0_0_0_1_0_0000);
        GTXTEST_DONE = 0;
        step(5);
        PLLLKDET = 0;
        step(2);
        chk("ll_sync_delay", outs(), 9'b0_0_0_1_0_0000);
        RATE_REQ = 1;
        GTXTEST_DONE = 1;
        step(1);
        chk("ll_wait_lock", outs(), 9'b1_1_0_0_0_0000);
`ifdef GTX_LOCK_LOSS_CNT_EN
        n_chk++;
        if (LOCK_LOSS_CNT === 8'd1) n_pass++;
        else $display("FAIL ll_count: got %0d expected 1", LOCK_LOSS_CNT);
`endif
        GTXTEST_DONE = 0;

        // Async reset in WAIT_TEST, then clean restart
        PLLLKDET = 1;
        wait_sig(1, 1'b0, 200, "ar_init_fall");
        step(20);
        chk("ar_wait_test", outs(), 9'b0_0_1_0_0_0000);
        #3 RST = 1'b1;
        #1 chk("ar_immediate", outs(), 9'b1_1_0_0_0_0000);
`ifdef GTX_LOCK_LOSS_CNT_EN
        n_chk++;
        if (LOCK_LOSS_CNT === 8'd0) n_pass++;
        else $display("FAIL ar_count: got %0d expected 0", LOCK_LOSS_CNT);
`endif
        step(2);
        RST = 1'b0;
        wait_sig(1, 1'b0, 200, "ar_restart_init");
        step(3);
        GTXTEST_DONE = 1;
        step(1);
        chk("ar_restart_ready", outs(), 9'b0_0_1_1_0_0000);
        GTXTEST_DONE = 0;

        // Persistent GTXTEST_DONE absence: seven timeouts into FAIL
        PLLLKDET = 1; TXRESETDONE = 1; RATE_REQ = 0; GTXTEST_DONE = 0;
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            logic [3:0] kk;
            kk = 4'(k);
            wait_sig(1, 1'b0, 200, $sformatf("fl_init_fall%0d", k));
            step(8191);
            chk($sformatf("fl_last%0d", k), outs(), {5'b0_0_0_0_0, kk - 4'd1});
            step(1);
            chk($sformatf("fl_retry%0d", k), outs(), {4'b1_1_0_0, (k == 7), kk});
        end
        PLLLKDET = 0;
        step(10);
        chk("fl_lock_low", outs(), 9'b1_1_0_0_1_0111);
        PLLLKDET = 1;
        GTXTEST_DONE = 1;
        step(10);
        chk("fl_lock_high", outs(), 9'b1_1_0_0_1_0111);
        GTXTEST_DONE = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gtx_tx_init_seq.md
Name: gtx_tx_init_seq

Overview:
- Power-up and rate-change sequencer for one GTX transmitter on the DAQ optical output path.
- Drives the GTX TXRESET and the INIT/TX_RATE inputs of the TX clock-divider reset stage, and consumes that stage's GTXTEST_DONE pulse.
- Raises TX_READY only after the full chain completes: PLL lock, TXRESET, TXRESETDONE, divider reset.
- Handles PLL lock loss, runtime rate-change requests and timeout retries.

Parameters:
RST_HOLD_CYCLES, 32, cycles TXRESET is held high after PLL lock (min 1)
RESETDONE_TIMEOUT, 4096, max cycles waiting for TXRESETDONE
TESTDONE_TIMEOUT, 8192, max cycles waiting for GTXTEST_DONE rising edge
MAX_RETRIES, 7, failed attempts before entering FAIL (1..15)
CTR_W, 13, timer width; must hold max(RST_HOLD_CYCLES, RESETDONE_TIMEOUT, TESTDONE_TIMEOUT)

Ports:
CLK  in  1  TX user clock; all logic is on its rising edge
RST  in  1  reset, asynchronous, active-high
PLLLKDET  in  1  GTX PLL lock, asynchronous; two-flop synchronised internally
TXRESETDONE  in  1  GTX reset done, asynchronous; two-flop synchronised internally
RATE_REQ  in  1  requested TX rate (0 = full, 1 = divided), synchronous to CLK
GTXTEST_DONE  in  1  divider-reset done pulse (1 to 4 cycles wide), synchronous
TXRESET  out  1  GTX TX reset
INIT  out  1  divider-reset stage restart
TX_RATE  out  1  applied rate, fed to GTX and divider-reset stage
TX_READY  out  1  link usable
TIMEOUT_ERR  out  1  sticky; FAIL reached
RETRY_CNT  out  4  failed attempts since last READY, saturating at MAX_RETRIES

Behaviour:
- Reset (async): state WAIT_LOCK, timer 0, TXRESET=1, INIT=1, TX_RATE=0, TX_READY=0, TIMEOUT_ERR=0, RETRY_CNT=0, synchronisers 0.
- States: WAIT_LOCK, TXRST, WAIT_RSTDONE, APPLY, WAIT_TEST, READY, FAIL. All outputs are registered.
- WAIT_LOCK:
  - TXRESET=1, INIT=1.
  - When lock_s (synchronised PLLLKDET) is 1, go to TXRST and clear the timer.
- TXRST:
  - TXRESET=1 for exactly RST_HOLD_CYCLES cycles, then go to WAIT_RSTDONE and clear the timer.
- WAIT_RSTDONE:
  - TXRESET=0, INIT=1.
  - When rstdone_s is 1, go to APPLY.
  - When the timer reaches RESETDONE_TIMEOUT-1 without rstdone_s, take the retry path.
- APPLY (one cycle):
  - INIT=1; TX_RATE is loaded from RATE_REQ, so TX_RATE is stable before INIT falls.
  - Next state is WAIT_TEST; clear the timer.
- WAIT_TEST:
  - INIT=0.
  - A rising edge of GTXTEST_DONE (level vs. previous-cycle register) moves to READY. Pulse width is irrelevant.
  - Timeout at TESTDONE_TIMEOUT-1 takes the retry path.
- READY:
  - TX_READY=1 from the cycle after the edge is detected. RETRY_CNT clears on entry.
  - If RATE_REQ != TX_RATE: TX_READY drops next cycle and the state goes to APPLY. TXRESET is not reasserted.
- Retry path:
  - RETRY_CNT+1.
  - If the new value equals MAX_RETRIES, go to FAIL; otherwise go to TXRST with the timer cleared.
- FAIL:
  - TXRESET=1, INIT=1, TX_READY=0, TIMEOUT_ERR=1.
  - Left only by RST; lock changes are ignored.
- Lock loss: lock_s=0 in any state except WAIT_LOCK and FAIL moves to WAIT_LOCK next cycle.
  - Lock loss has priority over timeout, rate request and GTXTEST_DONE in the same cycle.
  - RETRY_CNT is not changed by lock loss.
- RATE_REQ toggling during WAIT_TEST is not sampled. It is acted on only from READY, so a request is never lost, only deferred.
- Timer: CTR_W bits, counts up, cleared on every state entry, never wraps (state always changes at its terminal value).

Optional Feature:
- Macro: GTX_LOCK_LOSS_CNT_EN.
- Defined:
  - Adds output LOCK_LOSS_CNT [7:0].
  - Counts lock-loss transitions taken out of READY only; saturates at 255; cleared by RST.
- Undefined: no port and no counter logic; behaviour is otherwise identical.

Decomposition:
- Shared package daq_optical_pkg holds:
  - the state enum encoding (3 bits; WAIT_LOCK=0 ... FAIL=6);
  - defaults for the three timeouts and MAX_RETRIES;
  - the rate encoding constants RATE_FULL=0 and RATE_DIV=1.
- Sub-module sync2_ff (two-flop synchroniser, async reset to 0), instantiated for PLLLKDET and TXRESETDONE.

Test Plan:
- Normal bring-up (defaults):
  - Stimulus: RST released; PLLLKDET=1 at cycle 10; TXRESETDONE=1 100 cycles after TXRESET falls; GTXTEST_DONE 4-cycle pulse 2048 cycles after INIT falls.
  - Response: TXRESET high exactly 32 cycles after lock_s; INIT falls one cycle after APPLY; TX_READY=1 one cycle after the pulse's rising edge; RETRY_CNT=0.
- Rate change:
  - Stimulus: in READY, RATE_REQ 0->1.
  - Response: TX_READY=0 next cycle; TX_RATE=1 while INIT is high; TXRESET stays 0; TX_READY returns after GTXTEST_DONE.
- Single TXRESETDONE timeout:
  - Stimulus: TXRESETDONE held 0 for 4096 cycles, then 1.
  - Response: RETRY_CNT=1; TXRESET re-pulsed for 32 cycles; READY reached; RETRY_CNT clears to 0.
- Persistent GTXTEST_DONE absence:
  - Response: 7 timeouts of 8192 cycles; RETRY_CNT steps 1..7; FAIL with TIMEOUT_ERR=1, TX_READY=0.
  - Then PLLLKDET toggled: no change until RST.
- Lock loss in READY:
  - Stimulus: PLLLKDET=0, in the same cycle as a GTXTEST_DONE edge and a RATE_REQ change.
  - Response: WAIT_LOCK; TXRESET=1 and INIT=1 within 3 cycles; LOCK_LOSS_CNT=1 when the macro is defined.
- Async reset mid-WAIT_TEST:
  - Response: all outputs at reset values immediately, without a clock edge; sequence restarts cleanly.
